// File: rtl/mem_req_sequencer.sv
// Sequences valid/ready read/write requests onto a single-port synchronous RAM pin interface.
// Define MEM_REQ_SEQUENCER_STATS_EN to add saturating rd_count/wr_count access counters.
module mem_req_sequencer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_chip_select,
    output logic                  mem_write_enable,
    output logic                  mem_output_enable,
`ifdef MEM_REQ_SEQUENCER_STATS_EN
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
`endif
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ADDR,
        S_RD_CAP,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_drive;
    logic                  w_accept;

    assign w_accept  = (r_state == S_IDLE) && req_valid;
    assign busy      = (r_state != S_IDLE);
    assign mem_addr  = r_addr;
    assign rsp_rdata = r_rdata;
    // The bus is only ever driven in WRITE, so there is no overlap with the RAM's read drive.
    assign mem_data  = w_drive ? r_wdata : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == S_RD_CAP) begin
                r_rdata <= mem_data;
            end
        end
    end

    always_comb begin
        w_next            = r_state;
        req_ready         = 1'b0;
        rsp_valid         = 1'b0;
        mem_chip_select   = 1'b0;
        mem_write_enable  = 1'b0;
        mem_output_enable = 1'b0;
        w_drive           = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = req_write ? S_WRITE : S_RD_ADDR;
                end
            end
            S_WRITE: begin
                mem_chip_select  = 1'b1;
                mem_write_enable = 1'b1;
                w_drive          = 1'b1;
                w_next           = S_IDLE;
            end
            S_RD_ADDR: begin
                mem_chip_select   = 1'b1;
                mem_output_enable = 1'b1;
                w_next            = S_RD_CAP;
            end
            S_RD_CAP: begin
                mem_chip_select   = 1'b1;
                mem_output_enable = 1'b1;
                w_next            = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef MEM_REQ_SEQUENCER_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if ((r_state == S_RESP) && rsp_ready && (r_rd_count != 16'hFFFF)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if ((r_state == S_WRITE) && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end
`endif

endmodule
